axi4_lite_slave_write_responder: RTL and testbench
==================================================

// Module: axi4_lite_slave_write_responder
// PURPOSE
//  Slave-side (responder) AXI4-Lite write-channel endpoint: accepts AW and W independently with
//  per-channel programmable ready delays, decodes the address against one region, issues a
//  one-cycle write strobe to a local register/memory port, and returns BRESP on the B channel.
//  Sits between the slave interface pins and the slave memory model; one transaction in flight.
// PARAMETERS
//  ADDRESS_WIDTH  32      address width (awaddr, wrAddr)
//  DATA_WIDTH     32      data width; DATA_WIDTH/8 strobe bits; legal values 32, 64
//  DELAY_WIDTH    5       width of ready-delay config inputs
//  BASE_ADDR      'h0     first byte address of decoded region
//  REGION_SIZE    'h1000  region size in bytes; decoded range is [BASE_ADDR, BASE_ADDR+REGION_SIZE)
// PORTS
//  aclk              in   1                 clock, all logic on rising edge
//  aresetn           in   1                 asynchronous, active-low reset
//  awaddr            in   ADDRESS_WIDTH     write address
//  awprot            in   3                 protection (awprotEnum); captured, passed to wrProt
//  awvalid           in   1                 AW valid
//  awready           out  1                 AW ready
//  wdata             in   DATA_WIDTH        write data
//  wstrb             in   DATA_WIDTH/8      byte strobes
//  wvalid            in   1                 W valid
//  wready            out  1                 W ready
//  bresp             out  2                 write response (brespEnum)
//  bvalid            out  1                 B valid
//  bready            in   1                 B ready
//  delayForAwready   in   DELAY_WIDTH       cycles of awvalid-high before awready may assert
//  delayForWready    in   DELAY_WIDTH       cycles of wvalid-high before wready may assert
//  wrEn              out  1                 one-cycle local write strobe
//  wrAddr            out  ADDRESS_WIDTH     awaddr-BASE_ADDR, byte offset
//  wrData            out  DATA_WIDTH        captured wdata
//  wrStrb            out  DATA_WIDTH/8      captured wstrb
//  wrProt            out  3                 captured awprot
// BEHAVIOUR
//  Reset (async, immediate): awready=0, wready=0, bvalid=0, bresp=WRITE_OKAY, wrEn=0, wrAddr/wrData/
//   wrStrb/wrProt=0, both holding buffers empty, delay counters 0, FSM=IDLE. Reset mid-transaction
//   drops bvalid/wrEn in the same cycle; the partial transaction is discarded.
//  Ready delay (AW and W identical, independent): counter increments each cycle valid=1 while its
//   buffer is empty, saturating at 2**DELAY_WIDTH-1; holds if valid drops. ready = valid & ~bufFull &
//   (cnt >= delay). delay=0 -> ready combinational in the first valid cycle. Delay input is live.
//  On handshake: capture payload into buffer, set bufFull, clear counter. Full buffer -> ready=0.
//  FSM IDLE -> COMMIT when awFull & wFull (both may fill on the same edge).
//   COMMIT (exactly 1 cycle): compute response; wrEn=1 only if response is WRITE_OKAY -> RESP.
//   RESP: bvalid=1, bresp stable until bready=1; on B handshake clear both buffers -> IDLE.
//  Latency: last of AW/W handshakes at edge N -> wrEn high cycle N+1 -> bvalid high cycle N+2.
//   Next awready/wready earliest the cycle after the B handshake (no overlap).
//  Response priority: awaddr outside region -> WRITE_DECERR; else awaddr[log2(DATA_WIDTH/8)-1:0]
//   != 0 -> WRITE_SLVERR; else WRITE_OKAY. Region check uses ADDRESS_WIDTH+1-bit arithmetic so
//   BASE_ADDR+REGION_SIZE at top of address space does not wrap. wstrb=0 is OKAY with wrEn=1.
//  WRITE_EXOKAY is never generated. bready high before bvalid is legal and is not registered.
// STRUCTURE
//  Axi4LiteGlobalsPkg: reuse brespEnum, awprotEnum; add typedef enum bit [1:0]
//   {IDLE, COMMIT, RESP} writeResponderStateEnum.
//  Sub-module axi4_lite_ready_delay (counter + ready generation), instantiated for AW and W.
// TESTING
//  Delays 0/0, AW+W same cycle, awaddr='h10, wdata='hDEADBEEF, wstrb='hF, bready=1 -> awready,wready
//   in the valid cycle; wrEn with wrAddr='h10 next; bvalid+WRITE_OKAY the cycle after.
//  delayForAwready=3, W 5 cycles before AW -> wready at delay 0, awready on 4th awvalid cycle;
//   wrEn exactly 1 cycle after the AW handshake.
//  awaddr=BASE_ADDR+REGION_SIZE -> WRITE_DECERR, no wrEn; awaddr='h2 -> WRITE_SLVERR, no wrEn.
//  bready held low 10 cycles -> bvalid/bresp stable; new AW/W not accepted until the cycle after the
//   B handshake.
//  aresetn low during RESP -> bvalid=0 immediately; after release a fresh write completes OKAY.
//  1000 random writes, random delays/bready stalls -> scoreboard: one wrEn and one B per AW/W pair.

Source files
------------

// File: rtl/axi4_lite_slave_write_responder_pkg.sv
// Shared types for the AXI4-Lite write responder: response codes, protection
// encodings, responder state and channel indices for the ready-delay array.
package axi4_lite_slave_write_responder_pkg;

    typedef enum logic [1:0] {
        WRITE_OKAY   = 2'b00,
        WRITE_EXOKAY = 2'b01,
        WRITE_SLVERR = 2'b10,
        WRITE_DECERR = 2'b11
    } bresp_e;

    // bit0 privileged, bit1 non-secure, bit2 instruction
    typedef enum logic [2:0] {
        PROT_UNPRIV_SECURE_DATA    = 3'b000,
        PROT_PRIV_SECURE_DATA      = 3'b001,
        PROT_UNPRIV_NONSECURE_DATA = 3'b010,
        PROT_PRIV_NONSECURE_DATA   = 3'b011,
        PROT_UNPRIV_SECURE_INSTR   = 3'b100,
        PROT_PRIV_SECURE_INSTR     = 3'b101,
        PROT_UNPRIV_NONSECURE_INSTR = 3'b110,
        PROT_PRIV_NONSECURE_INSTR  = 3'b111
    } awprot_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RESP   = 2'd2
    } write_responder_state_e;

    localparam int AW_CH  = 0;
    localparam int W_CH   = 1;
    localparam int NUM_CH = 2;

endpackage

// File: rtl/axi4_lite_slave_write_responder_ready_delay.sv
// Per-channel ready generator: counts valid-high cycles while the channel
// buffer is empty and raises ready once the count reaches the live delay.
module axi4_lite_ready_delay
    import axi4_lite_slave_write_responder_pkg::*;
#(
    parameter int DELAY_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   buf_full,
    input  logic [DELAY_WIDTH-1:0] delay,
    output logic                   ready
);

    localparam logic [DELAY_WIDTH-1:0] CNT_MAX = '1;

    logic [DELAY_WIDTH-1:0] cnt_reg;
    logic [DELAY_WIDTH-1:0] cnt_next;
    logic                   counting;

    assign counting = valid & ~buf_full;
    // Gated by reset so ready stays low while the block is held in reset.
    assign ready    = rst_n & counting & (cnt_reg >= delay);

    always_comb begin
        cnt_next = cnt_reg;
        if (ready) begin
            cnt_next = '0;
        end else if (counting && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite write-channel slave endpoint: buffers one AW and one W beat, decodes
// the address, pulses a local write strobe and returns the B response.
module axi4_lite_slave_write_responder
    import axi4_lite_slave_write_responder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DELAY_WIDTH   = 5,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [ADDRESS_WIDTH:0]   REGION_SIZE   = 'h1000
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [DELAY_WIDTH-1:0]    delayForAwready,
    input  logic [DELAY_WIDTH-1:0]    delayForWready,
    output logic                      wrEn,
    output logic [ADDRESS_WIDTH-1:0]  wrAddr,
    output logic [DATA_WIDTH-1:0]     wrData,
    output logic [DATA_WIDTH/8-1:0]   wrStrb,
    output logic [2:0]                wrProt
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    // One extra bit so a region ending at the top of the address space does not wrap.
    localparam logic [ADDRESS_WIDTH:0] REGION_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDRESS_WIDTH:0] REGION_HI = REGION_LO + REGION_SIZE;

    write_responder_state_e state_reg, state_next;
    bresp_e                 bresp_reg;
    bresp_e                 aw_resp_reg, aw_resp_next;
    awprot_e                aw_prot_reg;
    logic                   aw_full_reg, w_full_reg;
    logic [ADDRESS_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0]    w_data_reg;
    logic [STRB_WIDTH-1:0]    w_strb_reg;

    logic [NUM_CH-1:0]      ch_valid, ch_full, ch_ready;
    logic [DELAY_WIDTH-1:0] ch_delay [NUM_CH];
    logic                   aw_hs, w_hs, b_hs, wr_en, b_valid;
    logic [ADDRESS_WIDTH:0] awaddr_ext;

    assign ch_valid[AW_CH] = awvalid;
    assign ch_valid[W_CH]  = wvalid;
    assign ch_full[AW_CH]  = aw_full_reg;
    assign ch_full[W_CH]   = w_full_reg;
    assign ch_delay[AW_CH] = delayForAwready;
    assign ch_delay[W_CH]  = delayForWready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready_delay
            axi4_lite_ready_delay #(
                .DELAY_WIDTH(DELAY_WIDTH)
            ) u_ready_delay (
                .clk      (aclk),
                .rst_n    (aresetn),
                .valid    (ch_valid[gi]),
                .buf_full (ch_full[gi]),
                .delay    (ch_delay[gi]),
                .ready    (ch_ready[gi])
            );
        end
    endgenerate

    // ready already includes valid, so ready alone marks a handshake.
    assign awready = ch_ready[AW_CH];
    assign wready  = ch_ready[W_CH];
    assign aw_hs   = ch_ready[AW_CH];
    assign w_hs    = ch_ready[W_CH];

    assign awaddr_ext = {1'b0, awaddr};

    always_comb begin
        aw_resp_next = WRITE_OKAY;
        if ((awaddr_ext < REGION_LO) || (awaddr_ext >= REGION_HI)) begin
            aw_resp_next = WRITE_DECERR;
        end else if (|awaddr[ADDR_LSB-1:0]) begin
            aw_resp_next = WRITE_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            wr_addr_reg <= '0;
            aw_prot_reg <= PROT_UNPRIV_SECURE_DATA;
            aw_resp_reg <= WRITE_OKAY;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                wr_addr_reg <= awaddr - BASE_ADDR;
                aw_prot_reg <= awprot_e'(awprot);
                aw_resp_reg <= aw_resp_next;
            end else if (b_hs) begin
                aw_full_reg <= 1'b0;
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end else if (b_hs) begin
                w_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            bresp_reg <= WRITE_OKAY;
        end else begin
            state_reg <= state_next;
            if (state_reg == COMMIT) begin
                bresp_reg <= aw_resp_reg;
            end
        end
    end

    // Counting a same-edge handshake as full lets wrEn follow the last handshake directly.
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        b_valid    = 1'b0;
        b_hs       = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((aw_full_reg | aw_hs) & (w_full_reg | w_hs)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                wr_en      = (aw_resp_reg == WRITE_OKAY);
                state_next = RESP;
            end
            RESP: begin
                b_valid = 1'b1;
                if (bready) begin
                    b_hs       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bvalid = b_valid;
    assign bresp  = bresp_reg;
    assign wrEn   = wr_en;
    assign wrAddr = wr_addr_reg;
    assign wrData = w_data_reg;
    assign wrStrb = w_strb_reg;
    assign wrProt = aw_prot_reg;

endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// Bench for the AXI4-Lite write responder: directed scenarios with literal
// expectations plus a per-cycle transaction-level model and scoreboard.
module tb_axi4_lite_slave_write_responder;

    localparam longint unsigned BASE = 64'h0;
    localparam longint unsigned SIZE = 64'h1000;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  delayForAwready;
    logic [4:0]  delayForWready;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrStrb;
    logic [2:0]  wrProt;

    int tests = 0;
    int fails = 0;
    int wren_count = 0;
    int b_count = 0;

    axi4_lite_slave_write_responder dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .awaddr          (awaddr),
        .awprot          (awprot),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wvalid          (wvalid),
        .wready          (wready),
        .bresp           (bresp),
        .bvalid          (bvalid),
        .bready          (bready),
        .delayForAwready (delayForAwready),
        .delayForWready  (delayForWready),
        .wrEn            (wrEn),
        .wrAddr          (wrAddr),
        .wrData          (wrData),
        .wrStrb          (wrStrb),
        .wrProt          (wrProt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Response rule straight from the address map: outside region, then alignment.
    function automatic logic [1:0] exp_code(logic [31:0] a);
        longint unsigned la;
        la = {32'b0, a};
        if (la < BASE || la >= BASE + SIZE) return 2'd3;
        if (a[1:0] != 2'b00) return 2'd2;
        return 2'd0;
    endfunction

    // Model state: what each channel holds, how long it has waited, and the
    // transaction phase (0 collecting, 1 commit cycle, 2 response pending).
    bit          m_aw_have, m_w_have;
    int          m_aw_wait, m_w_wait, m_stage;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    bit          e_awr, e_wr, e_wren, e_bvalid;

    initial begin
        m_aw_have = 0; m_w_have = 0; m_aw_wait = 0; m_w_wait = 0; m_stage = 0;
        m_addr = 0; m_data = 0; m_strb = 0; m_prot = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                chk("rst_awready", awready, 0);
                chk("rst_wready", wready, 0);
                chk("rst_bvalid", bvalid, 0);
                chk("rst_bresp", bresp, 0);
                chk("rst_wren", wrEn, 0);
                chk("rst_wraddr", wrAddr, 0);
                chk("rst_wrdata", wrData, 0);
                chk("rst_wrstrb", wrStrb, 0);
                chk("rst_wrprot", wrProt, 0);
                m_aw_have = 0; m_w_have = 0; m_aw_wait = 0; m_w_wait = 0; m_stage = 0;
            end else begin
                e_awr    = awvalid && !m_aw_have && (m_aw_wait >= int'(delayForAwready));
                e_wr     = wvalid && !m_w_have && (m_w_wait >= int'(delayForWready));
                e_wren   = (m_stage == 1) && (exp_code(m_addr) == 2'd0);
                e_bvalid = (m_stage == 2);
                chk("awready", awready, e_awr);
                chk("wready", wready, e_wr);
                chk("wren", wrEn, e_wren);
                chk("bvalid", bvalid, e_bvalid);
                if (e_wren) begin
                    chk("wraddr", wrAddr, m_addr - 32'(BASE));
                    chk("wrdata", wrData, m_data);
                    chk("wrstrb", wrStrb, m_strb);
                    chk("wrprot", wrProt, m_prot);
                end
                if (e_bvalid) chk("bresp", bresp, exp_code(m_addr));
                if (wrEn) wren_count++;
                if (bvalid && bready) b_count++;
                if (e_awr) begin
                    m_aw_have = 1; m_addr = awaddr; m_prot = awprot; m_aw_wait = 0;
                end else if (awvalid && !m_aw_have && m_aw_wait < 31) begin
                    m_aw_wait++;
                end
                if (e_wr) begin
                    m_w_have = 1; m_data = wdata; m_strb = wstrb; m_w_wait = 0;
                end else if (wvalid && !m_w_have && m_w_wait < 31) begin
                    m_w_wait++;
                end
                case (m_stage)
                    0: if (m_aw_have && m_w_have) m_stage = 1;
                    1: m_stage = 2;
                    default: if (bready) begin
                        m_stage = 0; m_aw_have = 0; m_w_have = 0;
                    end
                endcase
            end
        end
    end

    task automatic aw_send(input logic [31:0] a, input logic [2:0] p, input int pre, output int ncyc);
        bit hs;
        hs = 0;
        ncyc = 0;
        repeat (pre) begin @(posedge aclk); #1; end
        awaddr = a; awprot = p; awvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            ncyc++;
            hs = awready;
            @(posedge aclk); #1;
            if (hs) break;
        end
        awvalid = 1'b0;
        chk("aw_handshake_done", hs, 1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input int pre, output int ncyc);
        bit hs;
        hs = 0;
        ncyc = 0;
        repeat (pre) begin @(posedge aclk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            ncyc++;
            hs = wready;
            @(posedge aclk); #1;
            if (hs) break;
        end
        wvalid = 1'b0;
        chk("w_handshake_done", hs, 1);
    endtask

    task automatic b_wait(input bit rand_b, output logic [1:0] resp);
        bit got;
        got = 0;
        resp = 2'b01;
        for (int c = 0; c < 300 && !got; c++) begin
            if (rand_b) bready = ($urandom_range(0, 2) != 0);
            @(negedge aclk);
            if (bvalid && bready) begin
                got = 1;
                resp = bresp;
            end
            @(posedge aclk); #1;
        end
        chk("b_handshake_done", got, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, input int aw_pre, input int w_pre,
                            input bit rand_b, output logic [1:0] resp, output int wren_seen);
        int wc0, n1, n2;
        wc0 = wren_count;
        fork
            aw_send(a, p, aw_pre, n1);
            w_send(d, s, w_pre, n2);
        join
        b_wait(rand_b, resp);
        wren_seen = wren_count - wc0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] a;
        int          ws, n1, n2, bc0, wc0, n_ok;
        bit          seen;

        aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 1; delayForAwready = 0; delayForWready = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        @(posedge aclk); #1;

        // 1: zero delays, AW and W together
        awaddr = 32'h10; awprot = 3'd0; awvalid = 1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        @(negedge aclk);
        chk("t1_awready", awready, 1);
        chk("t1_wready", wready, 1);
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge aclk);
        chk("t1_wren", wrEn, 1);
        chk("t1_wraddr", wrAddr, 32'h10);
        chk("t1_wrdata", wrData, 32'hDEADBEEF);
        @(posedge aclk);
        @(negedge aclk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'd0);
        @(posedge aclk); #1;

        // 2: AW delay 3, W arrives 5 cycles before AW
        delayForAwready = 5'd3;
        fork
            w_send(32'h12345678, 4'hF, 0, n2);
            aw_send(32'h8, 3'd5, 5, n1);
        join
        chk("t2_w_cycles", n2, 1);
        chk("t2_aw_cycles", n1, 4);
        @(negedge aclk);
        chk("t2_wren_after_aw", wrEn, 1);
        @(posedge aclk); #1;
        b_wait(0, resp);
        chk("t2_bresp", resp, 2'd0);
        delayForAwready = 5'd0;

        // 3: decode errors and region edge
        do_write(32'h1000, 32'hA5A5A5A5, 4'hF, 3'd0, 0, 1, 0, resp, ws);
        chk("t3_decerr_bresp", resp, 2'd3);
        chk("t3_decerr_wren", ws, 0);
        do_write(32'h2, 32'h5A5A5A5A, 4'hF, 3'd0, 1, 0, 0, resp, ws);
        chk("t3_slverr_bresp", resp, 2'd2);
        chk("t3_slverr_wren", ws, 0);
        do_write(32'hFFC, 32'h0BADF00D, 4'h0, 3'd7, 0, 0, 0, resp, ws);
        chk("t3_edge_bresp", resp, 2'd0);
        chk("t3_edge_wren", ws, 1);

        // 4: bready stall with the next AW/W already waiting
        bready = 0;
        fork
            aw_send(32'h20, 3'd1, 0, n1);
            w_send(32'h11112222, 4'hF, 0, n2);
        join
        awaddr = 32'h24; awvalid = 1; wdata = 32'h33334444; wstrb = 4'h3; wvalid = 1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (bvalid) begin seen = 1; break; end
            @(posedge aclk); #1;
        end
        chk("t4_bvalid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(posedge aclk); @(negedge aclk); end
            chk("t4_stall_bvalid", bvalid, 1);
            chk("t4_stall_bresp", bresp, 2'd0);
            chk("t4_stall_awready", awready, 0);
            chk("t4_stall_wready", wready, 0);
        end
        @(posedge aclk); #1;
        bready = 1;
        @(negedge aclk);
        chk("t4_bhs_bvalid", bvalid, 1);
        chk("t4_bhs_awready", awready, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t4_after_awready", awready, 1);
        chk("t4_after_wready", wready, 1);
        chk("t4_after_bvalid", bvalid, 0);
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        b_wait(0, resp);
        chk("t4_second_bresp", resp, 2'd0);

        // 5: reset while the response is pending
        bready = 0;
        fork
            aw_send(32'h30, 3'd0, 0, n1);
            w_send(32'hCAFEF00D, 4'hF, 0, n2);
        join
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (bvalid) begin seen = 1; break; end
            @(posedge aclk); #1;
        end
        chk("t5_bvalid_seen", seen, 1);
        @(posedge aclk); #1;
        aresetn = 0;
        #1;
        chk("t5_async_bvalid", bvalid, 0);
        chk("t5_async_wren", wrEn, 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;
        bready = 1;
        do_write(32'h40, 32'h01020304, 4'hF, 3'd2, 0, 0, 0, resp, ws);
        chk("t5_fresh_bresp", resp, 2'd0);
        chk("t5_fresh_wren", ws, 1);

        // 6: random traffic with scoreboard totals
        bc0 = b_count;
        wc0 = wren_count;
        n_ok = 0;
        for (int i = 0; i < 1000; i++) begin
            delayForAwready = 5'($urandom_range(0, 7));
            delayForWready  = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: a = 32'h1000 + $urandom_range(0, 32'hFFFF);
                1: a = ($urandom_range(0, 32'h3FF) << 2) | $urandom_range(1, 3);
                2: a = 32'hFFFF_FFFC;
                default: a = $urandom_range(0, 32'h3FF) << 2;
            endcase
            do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 4), $urandom_range(0, 4), 1, resp, ws);
            chk("rand_bresp", resp, exp_code(a));
            chk("rand_wren_per_tx", ws, (exp_code(a) == 2'd0) ? 1 : 0);
            if (exp_code(a) == 2'd0) n_ok++;
        end
        chk("sb_b_per_pair", b_count - bc0, 1000);
        chk("sb_wren_per_ok_pair", wren_count - wc0, n_ok);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
